// File: rtl/mssv_pkg.sv
// Shared definitions for the MSSV digit-sequence detector, its sequencer and models.
package mssv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam int DW      = 3;
    localparam int SW      = 4;
    localparam int DET_LAT = 1;

    // Digits of the valid sequence, oldest first.
    localparam logic [DW-1:0] SEQ_D0 = 3'd0;
    localparam logic [DW-1:0] SEQ_D1 = 3'd6;
    localparam logic [DW-1:0] SEQ_D2 = 3'd4;
    localparam logic [DW-1:0] SEQ_D3 = 3'd2;

    function automatic logic is_seq(input logic [4*DW-1:0] win);
        return win == {SEQ_D0, SEQ_D1, SEQ_D2, SEQ_D3};
    endfunction

endpackage

// File: rtl/mssv_digit_buf.sv
// DEPTH x DW digit register file: synchronous write, combinational read, async clear.
module mssv_digit_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next contents of the buffer.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: {DW{1'b0}}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mssv_seq_ctrl.sv
// Sequencer for the MSSV detector: streams the digit buffer into the detector,
// counts detections and captures the final running sum.
module mssv_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 3,
    parameter int SW    = 4,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] match_cnt,
    output logic [SW-1:0] last_sum,
    output logic          det_rst,
    output logic [DW-1:0] det_inp,
    input  logic          det_done,
    input  logic [SW-1:0] det_sum
);
    import mssv_pkg::*;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_L  = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_L   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          det_rst_q, det_rst_d;

    logic          len_ok_s;
    logic          buf_we_s;
    logic [DW-1:0] rd_data_s;
    logic [CW-1:0] cnt_inc_s;

    assign len_ok_s  = (len != ZERO_L) && (len <= DEPTH_L);
    assign buf_we_s  = cfg_we && ((state_q == IDLE) || (state_q == FIN))
                       && ({1'b0, cfg_addr} < DEPTH_L);
    assign cnt_inc_s = (det_done && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

    mssv_digit_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we_s),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (ptr_q),
        .rdata (rd_data_s)
    );

    // Next state, pointer, counter and capture; outputs are decoded from the next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start && len_ok_s) begin
                    state_d = RUN;
                    len_d   = len;
                    ptr_d   = {AW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // det_done during ptr==0 still belongs to the detector's reset state.
                    if (ptr_q != {AW{1'b0}}) begin
                        cnt_d = cnt_inc_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if ({1'b0, ptr_q} == (len_q - ONE_L)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_inc_s;
                    sum_d   = det_sum;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d == RUN) || (state_d == DRAIN);
        done_d    = (state_d == FIN);
        det_rst_d = !busy_d;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= {AW{1'b0}};
            len_q     <= {(AW+1){1'b0}};
            cnt_q     <= {CW{1'b0}};
            sum_q     <= {SW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            det_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            det_rst_q <= det_rst_d;
        end
    end

    // Digit presented to the detector only while streaming.
    always_comb begin
        if (state_q == RUN) begin
            det_inp = rd_data_s;
        end else begin
            det_inp = {DW{1'b0}};
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign det_rst   = det_rst_q;
    assign match_cnt = cnt_q;
    assign last_sum  = sum_q;

endmodule

// File: tb/tb_mssv_seq_ctrl.sv
// Randomized scoreboard bench for mssv_seq_ctrl with a behavioural detector in the loop.
module tb_mssv_seq_ctrl;
    import mssv_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CW_TB   = 2;
    localparam int CNT_MAX = (1 << CW_TB) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = 4'd0;
    logic [2:0]   cfg_data = 3'd0;
    logic [4:0]   len_i = 5'd0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         busy, done, err, det_rst, det_done;
    logic [1:0]   match_cnt;
    logic [3:0]   last_sum, det_sum;
    logic [2:0]   det_inp;

    mssv_seq_ctrl #(.DEPTH(16), .AW(4), .DW(3), .SW(4), .CW(CW_TB)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .len(len_i), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
        .match_cnt(match_cnt), .last_sum(last_sum), .det_rst(det_rst), .det_inp(det_inp),
        .det_done(det_done), .det_sum(det_sum)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Detector stand-in: flags 0,6,4,2 one cycle after the last digit, keeps a running sum.
    logic [2:0] h0, h1, h2;
    int         nseen;
    always @(posedge clk or posedge rst) begin
        if (rst || det_rst) begin
            det_done <= 1'b0; det_sum <= 4'd0; nseen <= 0;
            h0 <= 3'd0; h1 <= 3'd0; h2 <= 3'd0;
        end else begin
            det_done <= (nseen >= 3) && is_seq({h2, h1, h0, det_inp});
            det_sum  <= det_sum + {1'b0, det_inp};
            h2 <= h1; h1 <= h0; h0 <= det_inp;
            nseen <= nseen + 1;
        end
    end

    int n_vec = 0;
    int n_mis = 0;

    function automatic void check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endfunction

    typedef struct {
        bit is_err;
        bit mk;
        int mcnt;
        int sum;
        int t;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: buffer image and last reported results.
    logic [2:0] mdl_mem [DEPTH];
    int         m_cnt   = 0;
    bit         m_known = 1'b1;
    int         m_sum   = 0;

    function automatic int ref_matches(input int l);
        int m = 0;
        for (int i = 3; i < l; i++)
            if (mdl_mem[i-3] == SEQ_D0 && mdl_mem[i-2] == SEQ_D1 &&
                mdl_mem[i-1] == SEQ_D2 && mdl_mem[i] == SEQ_D3) m++;
        return (m > CNT_MAX) ? CNT_MAX : m;
    endfunction

    function automatic int ref_sum(input int l);
        int s = 0;
        for (int i = 0; i < l; i++) s += int'(mdl_mem[i]);
        return s % 16;
    endfunction

    // Monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (done || err)) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_mis++;
                $display("FAIL unexpected_pulse: done=%0d err=%0d, expected no pulse", done, err);
            end else begin
                e = exp_q.pop_front();
                check("pulse_is_err", int'(err), int'(e.is_err));
                check("pulse_is_done", int'(done), int'(!e.is_err));
                check("pulse_cycle", cyc_cnt, e.t);
                if (e.mk) check("match_cnt", int'(match_cnt), e.mcnt);
                check("last_sum", int'(last_sum), e.sum);
            end
        end
    end

    task automatic write_digit(input int a, input logic [2:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d;
        mdl_mem[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic write_seq(input int base);
        write_digit(base,     SEQ_D0);
        write_digit(base + 1, SEQ_D1);
        write_digit(base + 2, SEQ_D2);
        write_digit(base + 3, SEQ_D3);
    endtask

    // One run request; abort_cyc==0 means no abort, poke adds start+cfg_we while busy.
    task automatic do_run(input int l, input int abort_cyc, input bit poke, input bit trace);
        int   t0;
        bit   ok;
        exp_t e;
        @(negedge clk);
        t0 = cyc_cnt;
        ok = (l >= 1) && (l <= DEPTH);
        len_i = 5'(l);
        start = 1'b1;
        if (!ok) begin
            e = '{is_err: 1'b1, mk: m_known, mcnt: m_cnt, sum: m_sum, t: t0 + 1};
            exp_q.push_back(e);
        end else if (abort_cyc == 0) begin
            e = '{is_err: 1'b0, mk: 1'b1, mcnt: ref_matches(l), sum: ref_sum(l), t: t0 + l + 2};
            exp_q.push_back(e);
            m_cnt = e.mcnt; m_known = 1'b1; m_sum = e.sum;
        end else begin
            m_known = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        if (!ok) begin
            check("rejected_busy", int'(busy), 0);
            return;
        end
        for (int c = 1; c <= l + 2; c++) begin
            if (trace && abort_cyc == 0) begin
                check("trace_busy", int'(busy), (c <= l + 1) ? 1 : 0);
                check("trace_det_rst", int'(det_rst), (c <= l + 1) ? 0 : 1);
                check("trace_det_inp", int'(det_inp), (c <= l) ? int'(mdl_mem[c-1]) : 0);
            end
            if (c == abort_cyc) abort = 1'b1;
            if (poke && c == 2) begin
                start = 1'b1;
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = mdl_mem[0] ^ 3'b101;
            end
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0;
            if (c == abort_cyc) begin
                abort = 1'b0;
                check("abort_busy", int'(busy), 0);
                check("abort_det_rst", int'(det_rst), 1);
                break;
            end
        end
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int l, ac;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 3'd0;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_match_cnt", int'(match_cnt), 0);
        check("rst_last_sum", int'(last_sum), 0);
        check("rst_det_rst", int'(det_rst), 1);
        check("rst_det_inp", int'(det_inp), 0);
        rst = 1'b0;

        // Single sequence, traced cycle by cycle.
        write_seq(0);
        do_run(4, 0, 1'b0, 1'b1);
        // Two sequences, then a broken one.
        write_seq(4);
        do_run(8, 0, 1'b0, 1'b0);
        write_digit(3, 3'd3);
        do_run(4, 0, 1'b0, 1'b0);
        // Rejected lengths, then start and cfg writes while busy.
        do_run(0, 0, 1'b0, 1'b0);
        do_run(17, 0, 1'b0, 1'b0);
        write_digit(3, SEQ_D3);
        do_run(8, 0, 1'b1, 1'b0);
        do_run(8, 0, 1'b0, 1'b0);
        // Abort mid-run, then abort together with start.
        do_run(8, 3, 1'b0, 1'b0);
        @(negedge clk);
        len_i = 5'd4; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        // Four sequences in sixteen digits saturate the counter.
        write_seq(8);
        write_seq(12);
        do_run(16, 0, 1'b0, 1'b1);

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 1) == 1) write_seq(int'($urandom_range(0, 12)));
            for (int w = 0; w < 3; w++)
                write_digit(int'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            l  = int'($urandom_range(0, 17));
            ac = 0;
            if (l >= 1 && l <= DEPTH && $urandom_range(0, 4) == 0)
                ac = int'($urandom_range(1, l + 1));
            do_run(l, ac, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        len_i = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_match_cnt", int'(match_cnt), 0);
        check("arst_last_sum", int'(last_sum), 0);
        check("arst_det_rst", int'(det_rst), 1);
        check("arst_det_inp", int'(det_inp), 0);
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 3'd0;
        m_cnt = 0; m_known = 1'b1; m_sum = 0;
        @(negedge clk);
        rst = 1'b0;
        // Cleared buffer streams zeros: no match and zero sum.
        do_run(16, 0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
